// File: rtl/byte_joining_n.sv
// Multi-lane byte joiner: buffers whole lane groups in a small FIFO
// and replays each group as a narrow stream, lane 0 first.
module byte_joining_n #(
  parameter  int WIDTH  = 8,
  parameter  int LANES  = 4,
  parameter  int DEPTH  = 2,
  parameter  int MODE_W = 2,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LANES*WIDTH-1:0] lanes_in,
  input  logic                   lanes_valid,
  output logic                   lanes_ready,
  input  logic [MODE_W-1:0]      lane_mode,
  output logic [WIDTH-1:0]       data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LW-1:0]          out_lane,
  output logic                   out_last,
  output logic                   mode_err
);

  localparam int LOG2L = $clog2(LANES);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [LANES*WIDTH-1:0] r_mem  [DEPTH];
  logic [LW-1:0]          r_lidx [DEPTH];
  logic [PW-1:0]          r_wr;
  logic [PW-1:0]          r_rd;
  logic [CW-1:0]          r_cnt;
  logic [LW-1:0]          r_sel;
  logic                   r_err;

  logic                   w_mode_ok;
  logic [LW-1:0]          w_nlast;
  logic [LANES*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]       w_lanes [LANES];
  logic                   w_valid;
  logic                   w_ready;
  logic                   w_last;
  logic                   w_push;
  logic                   w_beat;
  logic                   w_pop;

  // Decode link width into the index of the last active lane.
  // Modes wider than the physical link fall back to all lanes.
  always_comb begin
    w_mode_ok = 1'b0;
    w_nlast   = LW'(LANES - 1);
    for (int m = 0; m <= LOG2L; m++) begin
      if (m < (1 << MODE_W)) begin
        if (lane_mode == MODE_W'(m)) begin
          w_mode_ok = 1'b1;
          w_nlast   = LW'((1 << m) - 1);
        end
      end
    end
  end

  assign w_head = r_mem[r_rd];

  // Split the head group into per-lane words.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_lanes[k] = w_head[k*WIDTH +: WIDTH];
    end
  end

  assign w_valid = (r_cnt != '0);
  assign w_ready = (r_cnt != CW'(DEPTH));
  assign w_last  = w_valid && (r_sel == r_lidx[r_rd]);
  assign w_push  = lanes_valid && w_ready;
  assign w_beat  = w_valid && out_ready;
  assign w_pop   = w_beat && w_last;

  assign lanes_ready = w_ready;
  assign out_valid   = w_valid;
  assign data_out    = w_valid ? w_lanes[r_sel] : '0;
  assign out_lane    = r_sel;
  assign out_last    = w_last;
  assign mode_err    = r_err;

  // Group storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr]  <= lanes_in;
      r_lidx[r_wr] <= w_nlast;
    end
  end

  // Pointers, occupancy, lane counter and sticky mode error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_sel <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_beat) begin
        r_sel <= w_last ? '0 : r_sel + LW'(1);
      end
      if (w_push && !w_mode_ok) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_joining_n.sv
// Bench for byte_joining_n: group pushes feed an expected-beat queue
// that a monitor drains as the DUT hands off bytes.
module tb_byte_joining_n;

  logic        clk;
  logic        reset_n;
  logic [31:0] lanes_in;
  logic        lanes_valid;
  logic        lanes_ready;
  logic [1:0]  lane_mode;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        mode_err;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] l;
    logic       last;
  } beat_t;

  beat_t q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] G0 = 32'h44332211;
  localparam logic [31:0] G1 = 32'hA4A3A2A1;
  localparam logic [31:0] G2 = 32'hB4B3B2B1;
  localparam logic [31:0] G3 = 32'hC4C3C2C1;

  byte_joining_n #(
    .WIDTH(8), .LANES(4), .DEPTH(2), .MODE_W(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .lanes_in(lanes_in),
    .lanes_valid(lanes_valid),
    .lanes_ready(lanes_ready),
    .lane_mode(lane_mode),
    .data_out(data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lane(out_lane),
    .out_last(out_last),
    .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // Sample just before each rising edge and score every handed-off beat.
  always begin
    beat_t e;
    @(negedge clk);
    #4;
    if (reset_n && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got d=%0h lane=%0d last=%0b want none",
                 data_out, out_lane, out_last);
      end else begin
        e = q.pop_front();
        if ({data_out, out_lane, out_last} !== e) begin
          bad++;
          $display("FAIL beat got d=%0h lane=%0d last=%0b want d=%0h lane=%0d last=%0b",
                   data_out, out_lane, out_last, e.d, e.l, e.last);
        end
      end
    end
  end

  task automatic expect_group(input logic [31:0] d, input logic [1:0] m);
    int n;
    beat_t b;
    n = (1 << m);
    if (n > 4) n = 4;
    for (int k = 0; k < n; k++) begin
      b.d    = d[k*8 +: 8];
      b.l    = 2'(k);
      b.last = (k == n - 1);
      q.push_back(b);
    end
  endtask

  // Hold a group on the lanes until the FIFO takes it.
  task automatic push(input logic [31:0] d, input logic [1:0] m);
    bit ok;
    ok = 0;
    lanes_in    = d;
    lane_mode   = m;
    lanes_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ok = lanes_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    lanes_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL push_timeout got ready=0 want accept of %h", d);
    end else begin
      expect_group(d, m);
    end
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d valid=%0b want 0 0",
               nm, q.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    lanes_valid = 0;
    lanes_in    = '0;
    lane_mode   = 2'd2;
    out_ready   = 1;
    reset_n     = 0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    total++;
    if ({lanes_ready, out_valid, out_lane, out_last, data_out, mode_err}
        !== {1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset got rdy=%0b v=%0b lane=%0d last=%0b d=%0h err=%0b want 1 0 0 0 0 0",
               lanes_ready, out_valid, out_lane, out_last, data_out, mode_err);
    end
  endtask

  task automatic test_x4;
    @(posedge clk);
    #1;
    push(G0, 2'd2);
    @(negedge clk);
    total++;
    if ({out_valid, data_out, out_lane} !== {1'b1, 8'h11, 2'd0}) begin
      bad++;
      $display("FAIL x4_latency got v=%0b d=%0h lane=%0d want 1 11 0",
               out_valid, data_out, out_lane);
    end
    wait_drain("x4");
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL x4_idle got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_modes;
    @(posedge clk);
    #1;
    push(G0, 2'd1);
    push(G0, 2'd0);
    wait_drain("modes");
  endtask

  task automatic test_backpressure;
    @(posedge clk);
    #1;
    out_ready = 0;
    push(G1, 2'd2);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, data_out, out_lane} !== {1'b1, 8'hA2, 2'd1}) begin
        bad++;
        $display("FAIL hold got v=%0b d=%0h lane=%0d want 1 a2 1",
                 out_valid, data_out, out_lane);
      end
    end
    @(posedge clk);
    #1;
    push(G2, 2'd2);
    @(negedge clk);
    total++;
    if (lanes_ready !== 1'b0) begin
      bad++;
      $display("FAIL full got rdy=%0b want 0", lanes_ready);
    end
    fork
      push(G3, 2'd2);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          total++;
          if ({lanes_ready, data_out} !== {1'b0, 8'hA2}) begin
            bad++;
            $display("FAIL full_hold got rdy=%0b d=%0h want 0 a2",
                     lanes_ready, data_out);
          end
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    wait_drain("bp");
  endtask

  task automatic test_simul;
    @(posedge clk);
    #1;
    out_ready = 0;
    push(G1, 2'd0);
    lanes_in    = G2;
    lane_mode   = 2'd2;
    lanes_valid = 1;
    out_ready   = 1;
    expect_group(G2, 2'd2);
    @(posedge clk);
    #1 lanes_valid = 0;
    @(negedge clk);
    total++;
    if ({out_valid, data_out, out_lane, lanes_ready}
        !== {1'b1, 8'hB1, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL simul got v=%0b d=%0h lane=%0d rdy=%0b want 1 b1 0 1",
               out_valid, data_out, out_lane, lanes_ready);
    end
    wait_drain("simul");
  endtask

  task automatic test_mode_err;
    @(posedge clk);
    #1;
    push(G3, 2'd3);
    @(negedge clk);
    total++;
    if (mode_err !== 1'b1) begin
      bad++;
      $display("FAIL mode_err_set got %0b want 1", mode_err);
    end
    @(posedge clk);
    #1;
    push(G0, 2'd1);
    wait_drain("merr");
    total++;
    if (mode_err !== 1'b1) begin
      bad++;
      $display("FAIL mode_err_sticky got %0b want 1", mode_err);
    end
  endtask

  task automatic test_async_reset;
    bit hit;
    hit = 0;
    @(posedge clk);
    #1;
    push(G1, 2'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && out_lane == 2'd2) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reach_lane2 got lane=%0d want 2", out_lane);
    end
    #2 reset_n = 0;
    #1;
    q.delete();
    total++;
    if ({out_valid, out_lane, out_last, mode_err, lanes_ready, data_out}
        !== {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL async_rst got v=%0b lane=%0d last=%0b err=%0b rdy=%0b d=%0h want 0 0 0 0 1 0",
               out_valid, out_lane, out_last, mode_err, lanes_ready, data_out);
    end
    repeat (2) @(negedge clk);
    #1 reset_n = 1;
    repeat (10) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_rst got v=%0b want 0", out_valid);
    end
  endtask

  initial begin
    clk = 0;
    test_reset();
    test_x4();
    test_modes();
    test_backpressure();
    test_simul();
    test_mode_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
